// File: rtl/reorder_buffer_mc_pkg.sv
// rtl/reorder_buffer_mc_pkg.sv - entry layout, type encodings and store helpers for reorder_buffer_mc
package reorder_buffer_mc_pkg;

  typedef enum logic [1:0] {
    ROB_REG  = 2'd0,
    ROB_ST   = 2'd1,
    ROB_BR   = 2'd2,
    ROB_JALR = 2'd3
  } rob_type_e;

  // RV32I store funct3 values
  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010
  } store_funct3_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } store_state_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_type_e   typ;
    logic [31:0] dest;
    logic [31:0] val;
    logic [2:0]  st_type;
    logic        mispred;
    logic [31:0] pc_correct;
  } rob_entry_t;

  function automatic logic [3:0] store_byte_en(input logic [2:0] st_type, input logic [1:0] off);
    case (st_type)
      ST_SB:   return 4'b0001 << off;
      ST_SH:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/rob_store_unit.sv
// rtl/rob_store_unit.sv - head-of-buffer store drain: FSM, byte enables and lane alignment
module rob_store_unit
  import reorder_buffer_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] val,
  input  logic [2:0]  st_type,
  input  logic        mem_resp,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  output logic        done
);

  store_state_e state_q, state_d;
  logic [31:0]  addr_q, wdata_q;
  logic [3:0]   be_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are latched on entry to WRITE so the cache sees them stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (state_q == S_IDLE && start) begin
      addr_q  <= {addr[31:2], 2'b00};
      wdata_q <= val << {addr[1:0], 3'b000};
      be_q    <= store_byte_en(st_type, addr[1:0]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)    state_d = S_WRITE;
      S_WRITE: if (mem_resp) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    done            = 1'b0;
    if (state_q == S_WRITE) begin
      mem_write       = 1'b1;
      mem_address     = addr_q;
      mem_wdata       = wdata_q;
      mem_byte_enable = be_q;
      done            = mem_resp;
    end
  end

endmodule

// File: rtl/reorder_buffer_mc.sv
// rtl/reorder_buffer_mc.sv - multi-commit reorder buffer with CDB bypass lookups and store drain
module reorder_buffer_mc
  import reorder_buffer_mc_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = $clog2(DEPTH + 1),
  parameter int NUM_CDB  = 4,
  parameter int NUM_RD   = 2,
  parameter int COMMIT_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      disp_valid,
  input  logic [1:0]                disp_type,
  input  logic [31:0]               disp_dest,
  input  logic [2:0]                disp_st_type,
  output logic                      disp_ready,
  output logic [TAG_W-1:0]          disp_tag,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*32-1:0]     cdb_val,
  input  logic [NUM_CDB*32-1:0]     cdb_addr,
  input  logic [NUM_CDB-1:0]        cdb_mispred,
  input  logic [NUM_CDB*32-1:0]     cdb_pc_correct,
  input  logic [NUM_RD*TAG_W-1:0]   rd_tag,
  output logic [NUM_RD-1:0]         rd_ready,
  output logic [NUM_RD*32-1:0]      rd_val,
  output logic [COMMIT_W-1:0]       cm_valid,
  output logic [COMMIT_W*5-1:0]     cm_rd,
  output logic [COMMIT_W*TAG_W-1:0] cm_tag,
  output logic [COMMIT_W*32-1:0]    cm_val,
  output logic                      mem_write,
  output logic [31:0]               mem_address,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_byte_enable,
  input  logic                      mem_resp,
  output logic                      new_store,
  output logic                      flush,
  output logic [31:0]               pc_correct,
  output logic                      br_mispredict,
  output logic                      jalr_mispredict,
  output logic                      trap,
  output logic [TAG_W-1:0]          count
);

  localparam int IDX_W = $clog2(DEPTH);

  // Tags are 1-based; storage is 0-based.
  function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
    return IDX_W'(t - TAG_W'(1));
  endfunction

  function automatic logic [TAG_W-1:0] tag_add(input logic [TAG_W-1:0] t, input int n);
    int s;
    s = int'(t) + n;
    if (s > DEPTH) s = s - DEPTH;
    return TAG_W'(s);
  endfunction

  function automatic logic tag_ok(input logic [TAG_W-1:0] t);
    return (t != '0) && (int'(t) <= DEPTH);
  endfunction

  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];
  rob_entry_t       disp_ent;
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [TAG_W-1:0] lane_tag [COMMIT_W];
  logic [IDX_W-1:0] lane_idx, head_idx, wb_idx, lk_idx;
  logic [TAG_W-1:0] wb_tag, lk_tag;
  logic [COMMIT_W-1:0] ret;
  logic [TAG_W-1:0] n_ret;
  logic             go, disp_fire, st_start, st_done;

  assign disp_ready = (count_q < TAG_W'(DEPTH));
  assign disp_tag   = tail_q;
  assign count      = count_q;
  assign disp_fire  = disp_valid && disp_ready;
  assign head_idx   = tag_idx(head_q);
  assign st_start   = ent_q[head_idx].busy && ent_q[head_idx].ready && (ent_q[head_idx].typ == ROB_ST);
  assign new_store  = st_done;

  rob_store_unit u_store (
    .clk             (clk),
    .rst             (rst),
    .start           (st_start),
    .addr            (ent_q[head_idx].dest),
    .val             (ent_q[head_idx].val),
    .st_type         (ent_q[head_idx].st_type),
    .mem_resp        (mem_resp),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .done            (st_done)
  );

  // Commit lanes: an in-order prefix of ready entries; a store only leaves from lane 0.
  always_comb begin
    ret             = '0;
    n_ret           = '0;
    cm_valid        = '0;
    cm_rd           = '0;
    cm_tag          = '0;
    cm_val          = '0;
    flush           = 1'b0;
    pc_correct      = '0;
    br_mispredict   = 1'b0;
    jalr_mispredict = 1'b0;
    trap            = 1'b0;
    lane_tag        = '{default: '0};
    lane_idx        = '0;
    go              = 1'b1;
    for (int k = 0; k < COMMIT_W; k++) begin
      lane_tag[k] = tag_add(head_q, k);
      lane_idx    = tag_idx(lane_tag[k]);
      if (go && ent_q[lane_idx].busy && ent_q[lane_idx].ready &&
          (ent_q[lane_idx].typ != ROB_ST || (k == 0 && st_done))) begin
        ret[k] = 1'b1;
        n_ret  = n_ret + TAG_W'(1);
        if (ent_q[lane_idx].typ == ROB_REG || ent_q[lane_idx].typ == ROB_JALR) begin
          cm_valid[k]                 = 1'b1;
          cm_rd[k*5 +: 5]             = ent_q[lane_idx].dest[4:0];
          cm_tag[k*TAG_W +: TAG_W]    = lane_tag[k];
          cm_val[k*32 +: 32]          = ent_q[lane_idx].val;
        end
        if (ent_q[lane_idx].typ == ROB_REG && ent_q[lane_idx].dest[31]) trap = 1'b1;
        if (ent_q[lane_idx].typ == ROB_BR && ent_q[lane_idx].pc_correct == ent_q[lane_idx].dest) trap = 1'b1;
        if ((ent_q[lane_idx].typ == ROB_BR || ent_q[lane_idx].typ == ROB_JALR) && ent_q[lane_idx].mispred) begin
          flush           = 1'b1;
          pc_correct      = ent_q[lane_idx].pc_correct;
          br_mispredict   = (ent_q[lane_idx].typ == ROB_BR);
          jalr_mispredict = (ent_q[lane_idx].typ == ROB_JALR);
          go              = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  always_comb begin
    disp_ent         = '0;
    disp_ent.busy    = 1'b1;
    disp_ent.typ     = rob_type_e'(disp_type);
    disp_ent.dest    = disp_dest;
    disp_ent.st_type = disp_st_type;
  end

  // Retire before write-back so a stray CDB write cannot revive a just-freed slot.
  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    wb_tag = '0;
    wb_idx = '0;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      head_d  = TAG_W'(1);
      tail_d  = TAG_W'(1);
      count_d = '0;
    end else begin
      for (int k = 0; k < COMMIT_W; k++) begin
        if (ret[k]) ent_d[tag_idx(lane_tag[k])] = '0;
      end
      for (int p = 0; p < NUM_CDB; p++) begin
        wb_tag = cdb_tag[p*TAG_W +: TAG_W];
        wb_idx = tag_idx(wb_tag);
        if (cdb_valid[p] && tag_ok(wb_tag) && ent_d[wb_idx].busy) begin
          ent_d[wb_idx].ready   = 1'b1;
          ent_d[wb_idx].val     = cdb_val[p*32 +: 32];
          ent_d[wb_idx].mispred = cdb_mispred[p];
          if (ent_d[wb_idx].typ == ROB_ST || ent_d[wb_idx].typ == ROB_BR)
            ent_d[wb_idx].dest = cdb_addr[p*32 +: 32];
          if (ent_d[wb_idx].typ == ROB_BR || ent_d[wb_idx].typ == ROB_JALR)
            ent_d[wb_idx].pc_correct = cdb_pc_correct[p*32 +: 32];
        end
      end
      if (disp_fire) begin
        ent_d[tag_idx(tail_q)] = disp_ent;
        tail_d = tag_add(tail_q, 1);
      end
      head_d  = tag_add(head_q, int'(n_ret));
      count_d = count_q + TAG_W'(disp_fire) - n_ret;
    end
  end

  // Lookups: a CDB result in flight overrides the stored entry.
  always_comb begin
    rd_ready = '0;
    rd_val   = '0;
    lk_tag   = '0;
    lk_idx   = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      lk_tag = rd_tag[r*TAG_W +: TAG_W];
      lk_idx = tag_idx(lk_tag);
      if (tag_ok(lk_tag)) begin
        if (ent_q[lk_idx].busy && ent_q[lk_idx].ready) begin
          rd_ready[r]        = 1'b1;
          rd_val[r*32 +: 32] = ent_q[lk_idx].val;
        end
        for (int p = 0; p < NUM_CDB; p++) begin
          if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == lk_tag) begin
            rd_ready[r]        = 1'b1;
            rd_val[r*32 +: 32] = cdb_val[p*32 +: 32];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= TAG_W'(1);
      tail_q  <= TAG_W'(1);
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// tb/tb_reorder_buffer_mc.sv - scoreboard bench for reorder_buffer_mc
module tb_reorder_buffer_mc;

  localparam int TAG_W = 5;
  localparam int NUM_CDB = 4;
  localparam int NUM_RD = 2;
  localparam int COMMIT_W = 2;
  localparam logic [1:0] T_REG = 2'd0, T_ST = 2'd1, T_BR = 2'd2, T_JALR = 2'd3;
  localparam logic [2:0] F_SB = 3'b000, F_SH = 3'b001, F_SW = 3'b010;

  logic clk = 1'b0;
  logic rst;
  logic disp_valid;
  logic [1:0] disp_type;
  logic [31:0] disp_dest;
  logic [2:0] disp_st_type;
  logic disp_ready;
  logic [TAG_W-1:0] disp_tag;
  logic [NUM_CDB-1:0] cdb_valid, cdb_mispred;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*32-1:0] cdb_val, cdb_addr, cdb_pc_correct;
  logic [NUM_RD*TAG_W-1:0] rd_tag;
  logic [NUM_RD-1:0] rd_ready;
  logic [NUM_RD*32-1:0] rd_val;
  logic [COMMIT_W-1:0] cm_valid;
  logic [COMMIT_W*5-1:0] cm_rd;
  logic [COMMIT_W*TAG_W-1:0] cm_tag;
  logic [COMMIT_W*32-1:0] cm_val;
  logic mem_write, mem_resp, new_store, flush, br_mispredict, jalr_mispredict, trap;
  logic [31:0] mem_address, mem_wdata, pc_correct;
  logic [3:0] mem_byte_enable;
  logic [TAG_W-1:0] count;

  typedef struct {
    logic [4:0]       rd;
    logic [TAG_W-1:0] tag;
    logic [31:0]      val;
  } cm_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_exp_t;

  cm_exp_t commit_q[$];
  st_exp_t store_q[$];
  int checks = 0;
  int errors = 0;

  reorder_buffer_mc dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_type(disp_type), .disp_dest(disp_dest),
    .disp_st_type(disp_st_type), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_addr(cdb_addr),
    .cdb_mispred(cdb_mispred), .cdb_pc_correct(cdb_pc_correct),
    .rd_tag(rd_tag), .rd_ready(rd_ready), .rd_val(rd_val),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp), .new_store(new_store),
    .flush(flush), .pc_correct(pc_correct), .br_mispredict(br_mispredict),
    .jalr_mispredict(jalr_mispredict), .trap(trap), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cdb();
    cdb_valid = '0; cdb_mispred = '0; cdb_tag = '0;
    cdb_val = '0; cdb_addr = '0; cdb_pc_correct = '0;
  endtask

  task automatic set_cdb(input int p, input logic [TAG_W-1:0] t, input logic [31:0] v,
                         input logic [31:0] a, input logic mp, input logic [31:0] pc);
    cdb_valid[p] = 1'b1;
    cdb_mispred[p] = mp;
    cdb_tag[p*TAG_W +: TAG_W] = t;
    cdb_val[p*32 +: 32] = v;
    cdb_addr[p*32 +: 32] = a;
    cdb_pc_correct[p*32 +: 32] = pc;
  endtask

  task automatic dispatch(input logic [1:0] ty, input logic [31:0] d, input logic [2:0] st);
    disp_valid = 1'b1; disp_type = ty; disp_dest = d; disp_st_type = st;
    next_cycle();
    disp_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (count == '0) break;
    end
    check(name, count, 0);
    next_cycle();
  endtask

  task automatic wait_mem_write(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_write) break;
    end
    check(name, mem_write, 1);
  endtask

  // Monitor: commits and store requests are checked against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < COMMIT_W; k++) begin
        if (cm_valid[k]) begin
          check("cm_expected", commit_q.size() != 0, 1);
          if (commit_q.size() != 0) begin
            cm_exp_t e;
            e = commit_q.pop_front();
            check("cm_rd", cm_rd[k*5 +: 5], e.rd);
            check("cm_tag", cm_tag[k*TAG_W +: TAG_W], e.tag);
            check("cm_val", cm_val[k*32 +: 32], e.val);
          end
        end
      end
      if (mem_write) begin
        check("st_expected", store_q.size() != 0, 1);
        if (store_q.size() != 0) begin
          check("mem_address", mem_address, store_q[0].addr);
          check("mem_wdata", mem_wdata, store_q[0].data);
          check("mem_byte_enable", mem_byte_enable, store_q[0].be);
          if (mem_resp) void'(store_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; disp_valid = 1'b0; disp_type = '0; disp_dest = '0; disp_st_type = '0;
    clear_cdb(); rd_tag = '0; mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_disp_tag", disp_tag, 1);
    check("rst_count", count, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_flush", flush, 0);
    check("rst_cm_valid", cm_valid, 0);
    check("rst_trap", trap, 0);
    next_cycle();
    rst = 1'b0;

    // Fill all 16 entries with REG ops, rd = tag
    for (int i = 1; i <= 16; i++) begin
      disp_valid = 1'b1; disp_type = T_REG; disp_dest = i;
      @(negedge clk);
      check("fill_tag", disp_tag, i);
      check("fill_ready", disp_ready, 1);
      next_cycle();
    end
    disp_dest = 32'h99;
    @(negedge clk);
    check("full_ready", disp_ready, 0);
    check("full_count", count, 16);
    check("full_tag", disp_tag, 1);
    next_cycle();
    disp_valid = 1'b0;

    // Tags 1 and 2 complete together
    set_cdb(0, 1, 32'h100, 0, 0, 0);
    set_cdb(1, 2, 32'h200, 0, 0, 0);
    commit_q.push_back('{5'd1, 5'd1, 32'h100});
    commit_q.push_back('{5'd2, 5'd2, 32'h200});
    @(negedge clk);
    check("wb_count", count, 16);
    next_cycle();
    clear_cdb();
    @(negedge clk);
    check("dual_cm_valid", cm_valid, 2'b11);
    check("full_commit_ready", disp_ready, 0);
    next_cycle();

    // Same-cycle bypass of tag 3; tag 4 still pending
    set_cdb(2, 3, 32'h333, 0, 0, 0);
    rd_tag = {5'd4, 5'd3};
    commit_q.push_back('{5'd3, 5'd3, 32'h333});
    @(negedge clk);
    check("after_dual_count", count, 14);
    check("after_dual_ready", disp_ready, 1);
    check("after_dual_tag", disp_tag, 1);
    check("bypass_ready", rd_ready, 2'b01);
    check("bypass_val", rd_val[31:0], 32'h333);
    next_cycle();
    clear_cdb();
    @(negedge clk);
    check("entry_ready", rd_ready, 2'b01);
    check("entry_val", rd_val[31:0], 32'h333);
    next_cycle();
    rd_tag = '0;

    // Drain tags 4..16
    begin
      int t;
      t = 4;
      while (t <= 16) begin
        for (int p = 0; p < NUM_CDB; p++) begin
          if (t <= 16) begin
            set_cdb(p, 5'(t), 32'h1000 + t, 0, 0, 0);
            commit_q.push_back('{5'(t), 5'(t), 32'h1000 + t});
            t++;
          end
        end
        next_cycle();
        clear_cdb();
      end
    end
    wait_empty("drain_count");

    // Store sb at 0x1003, ack in the third WRITE cycle
    dispatch(T_ST, 0, F_SB);
    set_cdb(0, 1, 32'hAB, 32'h1003, 0, 0);
    store_q.push_back('{32'h1000, 32'hAB000000, 4'b1000});
    next_cycle();
    clear_cdb();
    wait_mem_write("sb_mem_write");
    next_cycle();
    next_cycle();
    mem_resp = 1'b1;
    @(negedge clk);
    check("sb_new_store", new_store, 1);
    next_cycle();
    mem_resp = 1'b0;
    @(negedge clk);
    check("sb_write_drop", mem_write, 0);
    check("sb_no_pulse", new_store, 0);
    check("sb_count", count, 0);
    next_cycle();

    // Store sh at 0x2006 followed by a REG that must wait behind it
    dispatch(T_ST, 0, F_SH);
    dispatch(T_REG, 6, F_SB);
    set_cdb(0, 2, 32'h1234, 32'h2006, 0, 0);
    set_cdb(1, 3, 32'h66, 0, 0, 0);
    store_q.push_back('{32'h2004, 32'h12340000, 4'b1100});
    commit_q.push_back('{5'd6, 5'd3, 32'h66});
    next_cycle();
    clear_cdb();
    wait_mem_write("sh_mem_write");
    check("sh_blocks_reg", count, 2);
    next_cycle();
    mem_resp = 1'b1;
    @(negedge clk);
    check("sh_new_store", new_store, 1);
    next_cycle();
    mem_resp = 1'b0;
    wait_empty("sh_count");

    // BR mispredict at lane 0 with a ready REG behind it
    dispatch(T_BR, 0, F_SB);
    dispatch(T_REG, 7, F_SB);
    set_cdb(0, 4, 32'h0, 32'h40, 1, 32'h60);
    set_cdb(1, 5, 32'h77, 0, 0, 0);
    next_cycle();
    clear_cdb();
    disp_valid = 1'b1; disp_type = T_REG; disp_dest = 8;
    @(negedge clk);
    check("br_flush", flush, 1);
    check("br_pc_correct", pc_correct, 32'h60);
    check("br_mispredict", br_mispredict, 1);
    check("br_jalr_flag", jalr_mispredict, 0);
    check("br_lane1_suppressed", cm_valid, 0);
    next_cycle();
    disp_valid = 1'b0;
    @(negedge clk);
    check("post_flush_count", count, 0);
    check("post_flush_tag", disp_tag, 1);
    check("post_flush_flush", flush, 0);
    next_cycle();

    // JALR mispredict from head 1: link write plus redirect
    dispatch(T_JALR, 1, F_SB);
    set_cdb(0, 1, 32'h44, 0, 1, 32'h100);
    commit_q.push_back('{5'd1, 5'd1, 32'h44});
    next_cycle();
    clear_cdb();
    @(negedge clk);
    check("jalr_flush", flush, 1);
    check("jalr_mispredict", jalr_mispredict, 1);
    check("jalr_br_flag", br_mispredict, 0);
    check("jalr_pc_correct", pc_correct, 32'h100);
    next_cycle();
    @(negedge clk);
    check("jalr_count", count, 0);
    next_cycle();

    // Branch-to-self and REG with dest[31] both raise trap
    dispatch(T_BR, 0, F_SB);
    dispatch(T_REG, 32'h80000005, F_SB);
    set_cdb(0, 1, 32'h0, 32'h80, 0, 32'h80);
    set_cdb(1, 2, 32'h55, 0, 0, 0);
    commit_q.push_back('{5'd5, 5'd2, 32'h55});
    next_cycle();
    clear_cdb();
    @(negedge clk);
    check("trap", trap, 1);
    check("trap_no_flush", flush, 0);
    check("trap_cm_valid", cm_valid, 2'b10);
    next_cycle();

    // Reset while a store is in WRITE; the late ack must be ignored
    dispatch(T_ST, 0, F_SW);
    set_cdb(0, 3, 32'hDEADBEEF, 32'h3000, 0, 0);
    store_q.push_back('{32'h3000, 32'hDEADBEEF, 4'b1111});
    next_cycle();
    clear_cdb();
    wait_mem_write("sw_mem_write");
    next_cycle();
    rst = 1'b1;
    store_q.delete();
    next_cycle();
    rst = 1'b0;
    mem_resp = 1'b1;
    @(negedge clk);
    check("rst_store_write", mem_write, 0);
    check("rst_store_pulse", new_store, 0);
    check("rst_store_count", count, 0);
    check("rst_store_tag", disp_tag, 1);
    next_cycle();
    mem_resp = 1'b0;
    @(negedge clk);
    check("late_resp_write", mem_write, 0);
    check("late_resp_count", count, 0);

    check("commit_q_empty", commit_q.size(), 0);
    check("store_q_empty", store_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
